// File: rtl/alu_seq_unit.sv
// alu_seq_unit: valid/ready execute unit.
// One-cycle ADD/SUB/logic ops, iterative shift-add MUL, plus flags.
module alu_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       oper,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ofl,
    output logic             cout,
    output logic             zero,
    output logic             illegal,
    output logic             busy,
    input  logic             clr_sticky,
    output logic             sticky_ofl
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   out_q, out_d;
    logic               ofl_q, ofl_d;
    logic               cout_q, cout_d;
    logic               illegal_q, illegal_d;
    logic               sticky_q, sticky_d;
    logic               has_res_q, has_res_d;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic               msign_q, msign_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic               hs;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_ofl;
    logic               alu_cout;
    logic               alu_ill;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_hi;
    logic               mul_ofl;

    assign in_ready   = (state_q == S_IDLE)
                      | ((state_q == S_DONE) & out_ready);
    assign accept     = in_valid & in_ready;
    assign out_valid  = (state_q == S_DONE);
    assign hs         = out_valid & out_ready;
    assign busy       = (state_q == S_MUL);
    assign out        = out_q;
    assign ofl        = ofl_q;
    assign cout       = cout_q;
    assign illegal    = illegal_q;
    assign sticky_ofl = sticky_q;
    // zero stays low until a first result has been written
    assign zero       = has_res_q & (out_q == '0);

    // Single-cycle datapath for every non-MUL operation
    always_comb begin
        sum      = '0;
        alu_out  = '0;
        alu_ofl  = 1'b0;
        alu_cout = 1'b0;
        alu_ill  = 1'b0;
        case (oper)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b}
                         + {{WIDTH{1'b0}}, cin};
                alu_out  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ofl  = sign
                         ? ((a[WIDTH-1] == b[WIDTH-1])
                            & (sum[WIDTH-1] != a[WIDTH-1]))
                         : sum[WIDTH];
            end
            OP_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b}
                         + (WIDTH+1)'(1);
                alu_out  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ofl  = sign
                         ? ((a[WIDTH-1] != b[WIDTH-1])
                            & (sum[WIDTH-1] != a[WIDTH-1]))
                         : ~sum[WIDTH];
            end
            OP_AND: alu_out = a & b;
            OP_OR:  alu_out = a | b;
            OP_XOR: alu_out = a ^ b;
            OP_MUL: alu_out = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Operand magnitudes and one shift-add step of the multiplier
    always_comb begin
        a_mag   = (sign & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag   = (sign & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod    = neg_q ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
        prod_hi = prod[2*WIDTH-1:WIDTH-1];
        if (msign_q) begin
            mul_ofl = !((&prod_hi) || (prod_hi == '0));
        end else begin
            mul_ofl = |prod[2*WIDTH-1:WIDTH];
        end
    end

    // FSM next state, result capture and multiplier iteration
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        ofl_d     = ofl_q;
        cout_d    = cout_q;
        illegal_d = illegal_q;
        has_res_d = has_res_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        msign_d   = msign_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    out_d     = prod[WIDTH-1:0];
                    ofl_d     = mul_ofl;
                    cout_d    = 1'b0;
                    illegal_d = 1'b0;
                    has_res_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a new request overrides the drain-to-idle decision above
        if (accept) begin
            if (oper == OP_MUL) begin
                state_d  = S_MUL;
                mcand_d  = {{WIDTH{1'b0}}, a_mag};
                mplier_d = b_mag;
                acc_d    = '0;
                cnt_d    = '0;
                neg_d    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                msign_d  = sign;
            end else begin
                state_d   = S_DONE;
                out_d     = alu_out;
                ofl_d     = alu_ofl;
                cout_d    = alu_cout;
                illegal_d = alu_ill;
                has_res_d = 1'b1;
            end
        end
    end

    // Sticky overflow: set on delivery wins over a same-cycle clear
    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (hs & ofl_q) begin
            sticky_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            out_q     <= '0;
            ofl_q     <= 1'b0;
            cout_q    <= 1'b0;
            illegal_q <= 1'b0;
            sticky_q  <= 1'b0;
            has_res_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            msign_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            ofl_q     <= ofl_d;
            cout_q    <= cout_d;
            illegal_q <= illegal_d;
            sticky_q  <= sticky_d;
            has_res_q <= has_res_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            msign_q   <= msign_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed and random checks of alu_seq_unit.
// Expected results come from a 64-bit reference model via a queue.
module tb_alu_seq_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [2:0]   oper = 3'b000;
    logic         sign = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         ofl;
    logic         cout;
    logic         zero;
    logic         illegal;
    logic         busy;
    logic         clr_sticky = 1'b0;
    logic         sticky_ofl;

    typedef struct packed {
        logic [15:0] out;
        logic        ofl;
        logic        cout;
        logic        zero;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .oper       (oper),
        .sign       (sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .ofl        (ofl),
        .cout       (cout),
        .zero       (zero),
        .illegal    (illegal),
        .busy       (busy),
        .clr_sticky (clr_sticky),
        .sticky_ofl (sticky_ofl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [15:0] x,
                                   input logic [15:0] y,
                                   input logic ci,
                                   input logic sg);
        exp_t   e;
        longint ux;
        longint uy;
        longint sx;
        longint sy;
        longint r;
        e  = '0;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 0;
        case (op)
            3'b000: begin
                r      = ux + uy + longint'(ci);
                e.out  = r[15:0];
                e.cout = r[16];
                r      = sx + sy + longint'(ci);
                e.ofl  = sg ? (r > 32767 || r < -32768) : e.cout;
            end
            3'b100: begin
                r      = ux - uy;
                e.out  = r[15:0];
                e.cout = (ux >= uy);
                r      = sx - sy;
                e.ofl  = sg ? (r > 32767 || r < -32768) : !e.cout;
            end
            3'b001: e.out = x & y;
            3'b010: e.out = x | y;
            3'b011: e.out = x ^ y;
            3'b101: begin
                if (sg) begin
                    r     = sx * sy;
                    e.out = r[15:0];
                    e.ofl = (r > 32767 || r < -32768);
                end else begin
                    r     = ux * uy;
                    e.out = r[15:0];
                    e.ofl = ((r >> 16) != 0);
                end
            end
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.out == 16'h0);
        return e;
    endfunction

    // Present a request while the unit is idle; push its expectation.
    task automatic issue(input logic [2:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic ci,
                         input logic sg);
        @(negedge clk);
        oper = op; a = x; b = y; cin = ci; sign = sg;
        in_valid = 1'b1;
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back(model(op, x, y, ci, sg));
    endtask

    // Wait (bounded) for out_valid, then compare against the queue head.
    task automatic collect(input string tag, input int exp_lat,
                           input int exp_busy);
        int   lat;
        int   bcnt;
        exp_t e;
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            lat++;
            if (busy) bcnt++;
        end while (!out_valid && lat < 200);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
        if (sb_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_out"}, 32'(out), 32'(e.out));
            chk({tag, "_flags_ofl_cout_zero_ill"},
                32'({ofl, cout, zero, illegal}),
                32'({e.ofl, e.cout, e.zero, e.illegal}));
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sg);
        issue(op, x, y, ci, sg);
        if (op == 3'b101) collect(tag, W + 1, W);
        else collect(tag, 1, 0);
        drain();
    endtask

    initial begin
        logic [2:0] rop;
        logic       seen;

        // reset values
        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_flags_ofl_cout_zero_ill",
            32'({ofl, cout, zero, illegal}), 32'd0);
        chk("rst_valid_busy_sticky",
            32'({out_valid, busy, sticky_ofl}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // directed arithmetic cases
        run_op("add_s_ovf", 3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        chk("sticky_after_ofl", 32'(sticky_ofl), 32'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_cleared", 32'(sticky_ofl), 32'd0);
        run_op("add_cin", 3'b000, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
        chk("sticky_no_ofl", 32'(sticky_ofl), 32'd0);
        run_op("add_u_wrap", 3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("sticky_after_wrap", 32'(sticky_ofl), 32'd1);
        run_op("sub_u", 3'b100, 16'h0003, 16'h0005, 1'b1, 1'b0);
        run_op("sub_s", 3'b100, 16'h0003, 16'h0005, 1'b0, 1'b1);
        run_op("sub_s_ovf", 3'b100, 16'h8000, 16'h0001, 1'b0, 1'b1);
        run_op("and", 3'b001, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
        run_op("or", 3'b010, 16'hF0F0, 16'h0F01, 1'b0, 1'b1);
        run_op("xor", 3'b011, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
        run_op("mul_s", 3'b101, 16'hFFFD, 16'h0005, 1'b0, 1'b1);
        run_op("mul_u_ovf", 3'b101, 16'h0100, 16'h0100, 1'b0, 1'b0);
        run_op("mul_s_minneg", 3'b101, 16'h8000, 16'h0001, 1'b0, 1'b1);
        run_op("mul_s_minneg_ovf", 3'b101, 16'h8000, 16'hFFFF,
               1'b0, 1'b1);
        run_op("mul_s_negneg", 3'b101, 16'hFF00, 16'hFF80, 1'b0, 1'b1);
        run_op("reserved", 3'b110, 16'h1234, 16'h5678, 1'b1, 1'b1);
        run_op("after_reserved", 3'b001, 16'h00FF, 16'h0F0F,
               1'b0, 1'b0);

        // backpressure, then drain with a same-cycle new request
        issue(3'b000, 16'h1234, 16'h1111, 1'b0, 1'b0);
        collect("bp", 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_out", 32'(out), 32'h2345);
            chk("bp_hold_valid_ready_ofl",
                32'({out_valid, in_ready, ofl, cout}), 32'b1000);
        end
        oper = 3'b011; a = 16'h5A5A; b = 16'h0FF0;
        cin = 1'b0; sign = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back(model(3'b011, 16'h5A5A, 16'h0FF0, 1'b0, 1'b0));
        collect("bp_next", 1, 0);
        drain();

        // random traffic
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 5));
            run_op("rand", rop, 16'($urandom), 16'($urandom),
                   1'($urandom), 1'($urandom));
        end

        // clear and set of sticky in the same cycle: set wins
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_clr2", 32'(sticky_ofl), 32'd0);
        issue(3'b000, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
        collect("sticky_race", 1, 0);
        clr_sticky = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        out_ready  = 1'b0;
        chk("sticky_set_wins", 32'(sticky_ofl), 32'd1);

        // async reset in the middle of a multiply
        @(negedge clk);
        oper = 3'b101; a = 16'h0123; b = 16'h0456;
        sign = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mul_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_flags_ofl_cout_zero_ill",
            32'({ofl, cout, zero, illegal}), 32'd0);
        chk("abort_valid_busy_sticky",
            32'({out_valid, busy, sticky_ofl}), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        run_op("post_reset", 3'b000, 16'h0100, 16'h0200, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
